// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: stalls the pipeline while a 32-bit load/store is split into
// two 16-bit SRAM half-accesses (low half first), each held WAIT_CYCLES cycles.
module mem_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [31:0] alu_res,
    input  logic [31:0] val_Rm,
    output logic        ready,
    output logic [31:0] read_data,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        is_wr, req, last, act, drive;
    logic [16:0] idx, idx_in;
    logic [31:0] wdata;

    assign req    = mem_read_en | mem_write_en;
    assign idx_in = 17'((alu_res - BASE_ADDR) >> 2);
    assign last   = cnt == LAST;
    assign ready  = state == DONE || (state == IDLE && !req);

    // SRAM pins depend only on registered state, so they move only on transitions
    assign act         = state == LO || state == HI;
    assign drive       = act && is_wr;
    assign sram_addr   = act ? {idx, state == HI} : '0;
    assign sram_dq_oe  = drive;
    assign sram_we_n   = !drive;
    assign sram_dq_out = !drive ? '0 : state == HI ? wdata[31:16] : wdata[15:0];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                cnt_nx   = '0;
                state_nx = req ? LO : IDLE;
            end
            LO, HI: begin
                cnt_nx = last ? '0 : cnt + 4'd1;
                if (last) state_nx = state == LO ? HI : DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            read_data <= '0;
            is_wr     <= 1'b0;
            idx       <= '0;
            wdata     <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req) begin
                is_wr <= mem_write_en;
                idx   <= idx_in;
                wdata <= val_Rm;
            end
            if (state == LO && last && !is_wr) read_data[15:0]  <= sram_dq_in;
            if (state == HI && last && !is_wr) read_data[31:16] <= sram_dq_in;
        end
    end
endmodule
